// File: rtl/traffic_scheduler_pkg.sv
// Shared types and constants for the UL/DL traffic scheduler.
package traffic_pkg;

    localparam int   PKT_ID_W      = 8;
    localparam logic TYPE_UL       = 1'b0;
    localparam logic TYPE_DL       = 1'b1;
    localparam int   DEPTH_DEF     = 4;
    localparam int   DL_WEIGHT_DEF = 2;

    typedef struct packed {
        logic [PKT_ID_W-1:0] id;
        logic                pkt_type;
    } pkt_t;

endpackage

// File: rtl/traffic_scheduler_fifo.sv
// Synchronous packet-ID FIFO with occupancy level; a push to a full queue is
// accepted only when the same cycle also pops.
module pkt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/traffic_scheduler.sv
// Two-queue UL/DL packet scheduler with credit-weighted arbitration feeding a
// registered ready/valid output stage.
module traffic_scheduler
    import traffic_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int DL_WEIGHT = DL_WEIGHT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [PKT_ID_W-1:0]     in_id,
    input  logic                    in_type,
    output logic                    out_valid,
    output logic [PKT_ID_W-1:0]     out_id,
    output logic                    out_type,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  ul_level,
    output logic [$clog2(DEPTH):0]  dl_level,
    output logic [7:0]              drop_count
);

    localparam int CW = $clog2(DL_WEIGHT + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DL_WEIGHT);

    logic                ul_push, dl_push, ul_pop, dl_pop;
    logic                ul_full, dl_full, ul_empty, dl_empty;
    logic [PKT_ID_W-1:0] ul_head, dl_head;
    logic                load, grant_ul, grant_dl, drop;
    logic [CW-1:0]       credit;
    pkt_t                sel_pkt;

    assign ul_push = in_valid && (in_type == TYPE_UL);
    assign dl_push = in_valid && (in_type == TYPE_DL);

    pkt_fifo #(.DEPTH(DEPTH), .W(PKT_ID_W)) u_ul_fifo (
        .clk(clk), .rst(rst), .push(ul_push), .pop(ul_pop), .din(in_id),
        .dout(ul_head), .full(ul_full), .empty(ul_empty), .level(ul_level)
    );

    pkt_fifo #(.DEPTH(DEPTH), .W(PKT_ID_W)) u_dl_fifo (
        .clk(clk), .rst(rst), .push(dl_push), .pop(dl_pop), .din(in_id),
        .dout(dl_head), .full(dl_full), .empty(dl_empty), .level(dl_level)
    );

    // UL wins only once DL has used up its credit, or when DL has nothing queued.
    assign load     = !out_valid || out_ready;
    assign grant_ul = !ul_empty && (dl_empty || credit == CREDIT_MAX);
    assign grant_dl = !dl_empty && !grant_ul;
    assign ul_pop   = load && grant_ul;
    assign dl_pop   = load && grant_dl;
    assign drop     = (ul_push && ul_full && !ul_pop) || (dl_push && dl_full && !dl_pop);

    always_comb begin
        sel_pkt = '{id: dl_head, pkt_type: TYPE_DL};
        if (grant_ul) sel_pkt = '{id: ul_head, pkt_type: TYPE_UL};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_type   <= 1'b0;
            credit     <= '0;
            drop_count <= '0;
        end else begin
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            if (load) begin
                out_valid <= grant_ul || grant_dl;
                if (grant_ul || grant_dl) begin
                    out_id   <= sel_pkt.id;
                    out_type <= sel_pkt.pkt_type;
                end
                if (grant_ul)
                    credit <= '0;
                else if (grant_dl)
                    credit <= (credit == CREDIT_MAX) ? CREDIT_MAX : credit + CW'(1);
            end
        end
    end

endmodule
